// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART-to-ALU sequencer: FSM state encoding,
// status-byte layout and the ALU opcode set.
package alu_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_B   = 3'd1,
    ST_WAIT_OP  = 3'd2,
    ST_EXEC     = 3'd3,
    ST_SEND_RES = 3'd4,
    ST_WAIT_RES = 3'd5,
    ST_SEND_FLG = 3'd6,
    ST_WAIT_FLG = 3'd7
  } state_t;

  // Bit of the returned status byte that carries the ALU overflow flag
  localparam int STATUS_OVF_BIT = 0;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/timeout_counter.sv
// Inter-byte watchdog: counts enabled cycles and flags the last allowed one.
// The count saturates instead of wrapping; TIMEOUT_CYCLES=0 never expires.
module timeout_counter #(
  parameter int NB_TIMEOUT     = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [NB_TIMEOUT-1:0] LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMEOUT-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + NB_TIMEOUT'(1);
    end
  end

  assign expire = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Sequencer between UART RX/TX and an external ALU: gathers A, B, opcode,
// then returns the result byte followed by a status byte.
module alu_uart_ctrl
  import alu_uart_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_TIMEOUT     = 20,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_overflow,
  output logic               o_busy,
  output logic               o_error
);

  state_t state;
  logic   flag;
  logic   waiting_rx;
  logic   expire;

  function automatic logic [NB_DATA-1:0] status_byte(input logic ovf);
    logic [NB_DATA-1:0] s;
    s = '0;
    s[STATUS_OVF_BIT] = ovf;
    return s;
  endfunction

  assign waiting_rx = (state == ST_WAIT_B) || (state == ST_WAIT_OP);
  assign o_busy     = (state != ST_IDLE);

  // Held at zero outside the mid-frame states, restarted by every accepted byte
  timeout_counter #(
    .NB_TIMEOUT     (NB_TIMEOUT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (i_clk),
    .reset  (i_reset),
    .clear  (i_rx_done || !waiting_rx),
    .enable (waiting_rx),
    .expire (expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      flag       <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_error    <= 1'b0;
      if (waiting_rx && expire && !i_rx_done) begin
        // A byte arriving in the last allowed cycle wins over the abort
        state    <= ST_IDLE;
        o_error  <= 1'b1;
        o_alu_a  <= '0;
        o_alu_b  <= '0;
        o_alu_op <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_rx_done) begin
              o_alu_a <= i_rx_data;
              state   <= ST_WAIT_B;
            end
          end
          ST_WAIT_B: begin
            if (i_rx_done) begin
              o_alu_b <= i_rx_data;
              state   <= ST_WAIT_OP;
            end
          end
          ST_WAIT_OP: begin
            if (i_rx_done) begin
              o_alu_op <= i_rx_data[NB_OP-1:0];
              state    <= ST_EXEC;
            end
          end
          ST_EXEC: begin
            // o_tx_data doubles as the result latch; it holds until the status byte
            o_tx_data  <= i_alu_result;
            flag       <= i_alu_overflow;
            o_tx_start <= 1'b1;
            state      <= ST_SEND_RES;
          end
          ST_SEND_RES: begin
            state <= ST_WAIT_RES;
          end
          ST_WAIT_RES: begin
            if (i_tx_done) begin
              o_tx_data  <= status_byte(flag);
              o_tx_start <= 1'b1;
              state      <= ST_SEND_FLG;
            end
          end
          ST_SEND_FLG: begin
            state <= ST_WAIT_FLG;
          end
          ST_WAIT_FLG: begin
            if (i_tx_done) begin
              state <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Bench for alu_uart_ctrl: byte-level reference model checked every cycle,
// directed frames with hand-computed results, timeout and reset scenarios.
module tb_alu_uart_ctrl;
  import alu_uart_pkg::*;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_done = 1'b0;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [7:0] alu_a, alu_b, alu_res;
  logic [5:0] alu_op;
  logic       alu_ovf;
  logic       busy, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: drives the DUT and also supplies model expectations
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic [7:0] r;
    logic       v;
    v = 1'b0;
    case (op)
      OP_ADD:  begin r = a + b; v = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB:  begin r = a - b; v = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_SRA:  r = $unsigned($signed(a) >>> b);
      OP_SRL:  r = a >> b;
      default: r = 8'hFF;
    endcase
    return {v, r};
  endfunction

  assign {alu_ovf, alu_res} = alu_ref(alu_a, alu_b, alu_op);

  alu_uart_ctrl #(
    .NB_DATA(8), .NB_OP(6), .NB_TIMEOUT(5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_rx_data(rx_data), .i_rx_done(rx_done),
    .i_tx_done(tx_done), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
    .i_alu_result(alu_res), .i_alu_overflow(alu_ovf),
    .o_busy(busy), .o_error(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: frame = three accepted bytes; reply = queue of bytes,
  // first one the cycle after the opcode edge, each next one on a tx_done.
  int         ecnt = 0, nb = 0, last_rx = 0, pulse_edge = -1, done_ok = 0;
  bit         sending = 0, model_on = 0, x_start = 0, x_err = 0;
  logic [7:0] ma = 0, mb = 0, x_data = 0;
  logic [5:0] mop = 0;
  logic [8:0] r9;
  logic [7:0] txq[$];

  always @(posedge clk) begin
    ecnt++;
    x_start = 0;
    x_err   = 0;
    if (rst) begin
      nb = 0; ma = 0; mb = 0; mop = 0; sending = 0; x_data = 0;
      txq.delete();
      model_on = 1;
    end else if (sending) begin
      if (ecnt == pulse_edge) begin
        x_start = 1; x_data = txq.pop_front(); done_ok = ecnt + 2;
      end else if (tx_done && ecnt >= done_ok) begin
        if (txq.size() > 0) begin
          x_start = 1; x_data = txq.pop_front(); pulse_edge = ecnt; done_ok = ecnt + 2;
        end else begin
          sending = 0;
        end
      end
    end else if (rx_done) begin
      last_rx = ecnt;
      case (nb)
        0: ma = rx_data;
        1: mb = rx_data;
        default: begin
          mop = rx_data[5:0];
          r9  = alu_ref(ma, mb, mop);
          txq.push_back(r9[7:0]);
          txq.push_back({7'd0, r9[8]});
          sending = 1; pulse_edge = ecnt + 1; done_ok = ecnt + 100000;
        end
      endcase
      nb = (nb == 2) ? 0 : nb + 1;
    end else if (nb > 0 && (ecnt - last_rx) == TMO) begin
      nb = 0; ma = 0; mb = 0; mop = 0; x_err = 1;
    end
  end

  logic [7:0] tx_log[$];
  int         err_pulses = 0;

  always @(negedge clk) begin
    if (model_on) begin
      check("tx_start", tx_start, x_start);
      check("tx_data",  tx_data,  x_data);
      check("error",    err,      x_err);
      check("busy",     busy,     (nb > 0) || sending);
      check("alu_a",    alu_a,    ma);
      check("alu_b",    alu_b,    mb);
      check("alu_op",   alu_op,   mop);
      if (tx_start) tx_log.push_back(tx_data);
      if (err) err_pulses++;
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk); rx_data = b; rx_done = 1'b1;
    @(negedge clk); rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
  endtask

  task automatic wait_start();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL start_wait: tx_start=0 for 40 cycles, required a pulse");
    end
  endtask

  task automatic serve_frame(input bit inject_rx);
    wait_start();
    repeat (2) @(negedge clk);
    if (inject_rx) send_rx(8'h55);
    pulse_tx_done();
    check("flag_start", tx_start, 1);
    repeat (2) @(negedge clk);
    pulse_tx_done();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp_res,
                           input logic [7:0] exp_st, input bit inject_rx);
    tx_log.delete();
    send_rx(a); send_rx(b); send_rx(op);
    serve_frame(inject_rx);
    check({name, "_count"}, tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      check({name, "_res"},    tx_log[0], exp_res);
      check({name, "_status"}, tx_log[1], exp_st);
    end
    check({name, "_idle"}, busy, 0);
  endtask

  initial begin
    int e0;
    // Pin the reference ALU with hand-computed values
    check("ref_add",  alu_ref(8'h05, 8'h03, OP_ADD), 9'h008);
    check("ref_ovf",  alu_ref(8'h7F, 8'h01, OP_ADD), 9'h180);
    check("ref_sub",  alu_ref(8'h03, 8'h05, OP_SUB), 9'h0FE);
    check("ref_und",  alu_ref(8'h12, 8'h34, 6'h3F),  9'h0FF);

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy",  busy,     0);
    check("rst_txd",   tx_data,  0);
    check("rst_start", tx_start, 0);
    check("rst_a",     alu_a,    0);
    check("rst_err",   err,      0);

    run_frame("add",    8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 0);
    run_frame("ovf",    8'h7F, 8'h01, 8'h20, 8'h80, 8'h01, 0);
    run_frame("sub",    8'h03, 8'h05, 8'h22, 8'hFE, 8'h00, 0);
    run_frame("undef",  8'h12, 8'h34, 8'h3F, 8'hFF, 8'h00, 0);
    run_frame("opmask", 8'h10, 8'h22, 8'hE0, 8'h32, 8'h00, 0);
    check("opmask_op", alu_op, 6'h20);
    run_frame("xor",    8'hF0, 8'h3C, 8'h26, 8'hCC, 8'h00, 0);

    // Partial frame abandoned
    e0 = err_pulses;
    send_rx(8'hAA);
    repeat (20) @(negedge clk);
    check("tmo_pulses", err_pulses - e0, 1);
    check("tmo_idle",   busy,  0);
    check("tmo_a_clr",  alu_a, 0);
    run_frame("after_tmo", 8'h01, 8'h02, 8'h20, 8'h03, 8'h00, 0);

    // Second byte lands on the last allowed cycle
    e0 = err_pulses;
    tx_log.delete();
    send_rx(8'h0A);
    repeat (TMO - 2) @(negedge clk);
    send_rx(8'h0B);
    send_rx(8'h20);
    serve_frame(0);
    check("edge_pulses", err_pulses - e0, 0);
    check("edge_count",  tx_log.size(), 2);
    if (tx_log.size() == 2) check("edge_res", tx_log[0], 8'h15);

    // Stray RX byte while waiting on TX, then a clean frame
    run_frame("and_ign", 8'h0C, 8'h06, 8'h24, 8'h04, 8'h00, 1);
    run_frame("srl",     8'h09, 8'h02, 8'h02, 8'h02, 8'h00, 0);

    // Reset while the result byte is in flight
    tx_log.delete();
    send_rx(8'h20); send_rx(8'h30); send_rx(8'h20);
    wait_start();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy",  busy,     0);
    check("mrst_txd",   tx_data,  0);
    check("mrst_start", tx_start, 0);
    check("mrst_a",     alu_a,    0);
    check("mrst_op",    alu_op,   0);
    pulse_tx_done();
    repeat (6) @(negedge clk);
    check("mrst_count", tx_log.size(), 1);
    if (tx_log.size() == 1) check("mrst_res", tx_log[0], 8'h50);

    run_frame("sra", 8'hF0, 8'h04, 8'h03, 8'hFF, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
